// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch button controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int DEF_DEBOUNCE_CYC  = 4;
    localparam int DEF_LONGPRESS_CYC = 16;
    localparam int DEF_MAX_LAPS      = 8;
    localparam int DEF_BUZZ_CYC      = 8;

    // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-count debouncer and registered
// rising-edge press detector for one raw push-button.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYC);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= btn;
            r_sync1 <= r_sync0;
        end
    end

    // Flip the debounced level only after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync1 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // One-cycle press event on each rising edge of the debounced level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced two-button IDLE/RUN/PAUSE sequencer driving the
// stopwatch reset/stop/record inputs, lap counter and ring-to-buzzer stretcher.
// Optional feature macro: STOPWATCH_CTRL_LONGPRESS_EN (long lr hold needed to
// reset from PAUSE; without it a single lr press resets immediately).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int LONGPRESS_CYC = DEF_LONGPRESS_CYC,
    parameter int MAX_LAPS      = DEF_MAX_LAPS,
    parameter int BUZZ_CYC      = DEF_BUZZ_CYC
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           btn_ss,
    input  logic                           btn_lr,
    input  logic                           ring,
    output logic                           sw_reset,
    output logic                           sw_stop,
    output logic                           sw_record,
    output logic                           running,
    output logic [$clog2(MAX_LAPS+1)-1:0]  lap_cnt,
    output logic                           lap_full,
    output logic                           buzzer
);

    localparam int LW = $clog2(MAX_LAPS + 1);
    localparam int BW = cnt_width(BUZZ_CYC);

    logic          w_ss_level;
    logic          w_ss_press;
    logic          w_lr_level;
    logic          w_lr_press;
    logic          w_ring_rise;
    logic          w_pause_reset;
    logic          w_unused_cfg;

    sw_state_t     r_state;
    logic          r_sw_reset;
    logic          r_sw_stop;
    logic          r_sw_record;
    logic          r_running;
    logic [LW-1:0] r_lap_cnt;
    logic          r_lap_full;
    logic          r_ring_d;
    logic [BW-1:0] r_buzz_cnt;
    logic          r_buzzer;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_ss (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_ss),
        .level (w_ss_level),
        .press (w_ss_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_lr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lr),
        .level (w_lr_level),
        .press (w_lr_press)
    );

`ifdef STOPWATCH_CTRL_LONGPRESS_EN
    localparam int HW = cnt_width(LONGPRESS_CYC);

    logic [HW-1:0] r_hold_cnt;

    // Count how long the lr level has been high; saturate so a hold fires only once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
        end else if (!w_lr_level) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != HW'(LONGPRESS_CYC)) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
        end
    end

    assign w_pause_reset = w_lr_level && (r_hold_cnt == HW'(LONGPRESS_CYC - 1));
    assign w_unused_cfg  = w_ss_level ^ w_lr_press;
`else
    assign w_pause_reset = w_lr_press;
    assign w_unused_cfg  = w_ss_level ^ w_lr_level ^ (LONGPRESS_CYC > 0);
`endif

    // Main sequencer; every output is registered here. ss always beats lr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_sw_reset  <= 1'b0;
            r_sw_stop   <= 1'b1;
            r_sw_record <= 1'b0;
            r_running   <= 1'b0;
            r_lap_cnt   <= '0;
            r_lap_full  <= 1'b0;
        end else begin
            r_sw_reset  <= 1'b0;
            r_sw_record <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_press) begin
                        r_state   <= ST_RUN;
                        r_sw_stop <= 1'b0;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_ss_press) begin
                        r_state   <= ST_PAUSE;
                        r_sw_stop <= 1'b1;
                        r_running <= 1'b0;
                    end else if (w_lr_press && !r_lap_full) begin
                        r_sw_record <= 1'b1;
                        r_lap_cnt   <= r_lap_cnt + LW'(1);
                        r_lap_full  <= (r_lap_cnt == LW'(MAX_LAPS - 1));
                    end
                end
                ST_PAUSE: begin
                    if (w_ss_press) begin
                        r_state   <= ST_RUN;
                        r_sw_stop <= 1'b0;
                        r_running <= 1'b1;
                    end else if (w_pause_reset) begin
                        r_state    <= ST_IDLE;
                        r_sw_reset <= 1'b1;
                        r_lap_cnt  <= '0;
                        r_lap_full <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_sw_stop <= 1'b1;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign w_ring_rise = ring & ~r_ring_d;

    // Stretch ring edges into a buzzer drive; button activity or a stopwatch reset silences it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ring_d   <= 1'b0;
            r_buzz_cnt <= '0;
            r_buzzer   <= 1'b0;
        end else begin
            r_ring_d <= ring;
            if (w_ss_press || w_lr_press || r_sw_reset) begin
                r_buzz_cnt <= '0;
                r_buzzer   <= 1'b0;
            end else if (w_ring_rise) begin
                r_buzz_cnt <= BW'(BUZZ_CYC);
                r_buzzer   <= (BUZZ_CYC > 0);
            end else if (r_buzz_cnt != '0) begin
                r_buzz_cnt <= r_buzz_cnt - BW'(1);
                r_buzzer   <= (r_buzz_cnt > BW'(1));
            end
        end
    end

    assign sw_reset  = r_sw_reset;
    assign sw_stop   = r_sw_stop;
    assign sw_record = r_sw_record;
    assign running   = r_running;
    assign lap_cnt   = r_lap_cnt;
    assign lap_full  = r_lap_full;
    assign buzzer    = r_buzzer;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a pulse scoreboard on sw_record/sw_reset.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic       ring = 1'b0;
    logic       sw_reset;
    logic       sw_stop;
    logic       sw_record;
    logic       running;
    logic [3:0] lap_cnt;
    logic       lap_full;
    logic       buzzer;

    always #5 clk = ~clk;

    stopwatch_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .btn_ss    (btn_ss),
        .btn_lr    (btn_lr),
        .ring      (ring),
        .sw_reset  (sw_reset),
        .sw_stop   (sw_stop),
        .sw_record (sw_record),
        .running   (running),
        .lap_cnt   (lap_cnt),
        .lap_full  (lap_full),
        .buzzer    (buzzer)
    );

    typedef struct {
        string      tag;
        logic       is_record;
        logic [3:0] lap;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_run_rise = 0;
    logic run_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the chosen buttons for 'hold' cycles, then release and let the debouncers settle.
    task automatic press(input logic ss, input logic lr, input int hold);
        btn_ss = ss;
        btn_lr = lr;
        cyc(hold);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        cyc(12);
    endtask

    task automatic push_exp(input string tag, input logic is_rec, input logic [3:0] lap);
        exp_t e;
        e.tag = tag;
        e.is_record = is_rec;
        e.lap = lap;
        sb_q.push_back(e);
    endtask

    task automatic lap_press(input int exp_lap, input bit pulse);
        if (pulse) push_exp($sformatf("rec%0d", exp_lap), 1'b1, 4'(exp_lap));
        press(1'b0, 1'b1, 6);
        chk($sformatf("lap_cnt_after_%0d", exp_lap), 32'(lap_cnt), 32'(exp_lap));
        chk($sformatf("lap_full_after_%0d", exp_lap), 32'(lap_full), 32'(exp_lap == 8));
    endtask

    // From PAUSE: reset the stopwatch through the lr button.
    task automatic lr_reset(input logic [3:0] lap_before);
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
        press(1'b0, 1'b1, 5);
        chk("short_hold_lap_kept", 32'(lap_cnt), 32'(lap_before));
        push_exp("long_reset", 1'b0, 4'd0);
        press(1'b0, 1'b1, 20);
`else
        chk("pause_lap_before", 32'(lap_cnt), 32'(lap_before));
        push_exp("lr_reset", 1'b0, 4'd0);
        press(1'b0, 1'b1, 6);
`endif
        chk("reset_lap_zero", 32'(lap_cnt), 32'd0);
        chk("reset_full_zero", 32'(lap_full), 32'd0);
        chk("reset_stop_high", 32'(sw_stop), 32'd1);
    endtask

    // Ring once (and optionally again 'second_at' cycles later); count buzzer-high cycles.
    task automatic buzz_run(input string tag, input int second_at, input int exp_hi);
        int hi;
        hi = 0;
        ring = 1'b1;
        cyc(1);
        ring = 1'b0;
        chk({tag, "_first"}, 32'(buzzer), 32'd1);
        for (int k = 0; k < 25; k++) begin
            hi += int'(buzzer);
            if (second_at > 0 && k == second_at - 1) ring = 1'b1;
            else ring = 1'b0;
            cyc(1);
        end
        chk({tag, "_len"}, 32'(hi), 32'(exp_hi));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sw_reset"},  32'(sw_reset),  32'd0);
        chk({tag, "_sw_stop"},   32'(sw_stop),   32'd1);
        chk({tag, "_sw_record"}, 32'(sw_record), 32'd0);
        chk({tag, "_running"},   32'(running),   32'd0);
        chk({tag, "_lap_cnt"},   32'(lap_cnt),   32'd0);
        chk({tag, "_lap_full"},  32'(lap_full),  32'd0);
        chk({tag, "_buzzer"},    32'(buzzer),    32'd0);
    endtask

    // Scoreboard consumer: every record/reset pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (running && !run_prev) n_run_rise++;
            if (sw_record || sw_reset) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, sw_record, sw_reset}, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    $display("pulse %s: record=%0b reset=%0b lap=%0d", sb_e.tag, sw_record, sw_reset, lap_cnt);
                    chk({sb_e.tag, "_kind"}, {30'd0, sw_record, sw_reset},
                        {30'd0, sb_e.is_record, ~sb_e.is_record});
                    if (sb_e.is_record) chk({sb_e.tag, "_lap"}, 32'(lap_cnt), 32'(sb_e.lap));
                end
            end
        end
        run_prev = running;
    end

    initial begin
        // Reset values while reset is held
        cyc(3);
        chk_reset_vals("rst");
        reset = 1'b1;
        cyc(3);

        // Test 1: start latency 3+DEBOUNCE_CYC = 7 cycles
        btn_ss = 1'b1;
        cyc(7);
        chk("t1_stop_c6", 32'(sw_stop), 32'd1);
        chk("t1_run_c6", 32'(running), 32'd0);
        cyc(1);
        chk("t1_stop_c7", 32'(sw_stop), 32'd0);
        chk("t1_run_c7", 32'(running), 32'd1);
        cyc(3);
        btn_ss = 1'b0;
        cyc(12);
        $display("t1 done: running=%0b", running);

        // Test 7: simultaneous presses in RUN -> PAUSE, no record
        press(1'b1, 1'b1, 6);
        chk("t7_running", 32'(running), 32'd0);
        chk("t7_stop", 32'(sw_stop), 32'd1);
        chk("t7_lap", 32'(lap_cnt), 32'd0);

        // Test 4: PAUSE with three laps, then lr reset
        press(1'b1, 1'b0, 6);
        chk("resume_running", 32'(running), 32'd1);
        for (int i = 1; i <= 3; i++) lap_press(i, 1'b1);
        press(1'b1, 1'b0, 6);
        chk("t4_paused", 32'(running), 32'd0);
        lr_reset(4'd3);
        press(1'b0, 1'b1, 6);
        chk("idle_lr_ignored", 32'(lap_cnt), 32'd0);

        // Test 3: nine laps, the ninth is dropped
        press(1'b1, 1'b0, 6);
        chk("t3_running", 32'(running), 32'd1);
        for (int i = 1; i <= 9; i++) lap_press((i <= 8) ? i : 8, i <= 8);

        // Test 5: buzzer stretch, reload, cancel by press
        buzz_run("t5a", 0, 8);
        buzz_run("t5b", 3, 11);
        btn_ss = 1'b1;
        cyc(4);
        ring = 1'b1;
        cyc(1);
        ring = 1'b0;
        chk("t5c_buzz_on", 32'(buzzer), 32'd1);
        cyc(2);
        chk("t5c_buzz_at_event", 32'(buzzer), 32'd1);
        cyc(1);
        chk("t5c_buzz_cleared", 32'(buzzer), 32'd0);
        chk("t5c_paused", 32'(running), 32'd0);
        cyc(3);
        btn_ss = 1'b0;
        cyc(12);
        lr_reset(4'd8);

        // Test 6: asynchronous reset mid-RUN
        press(1'b1, 1'b0, 6);
        lap_press(1, 1'b1);
        lap_press(2, 1'b1);
        ring = 1'b1;
        cyc(1);
        ring = 1'b0;
        chk("t6_pre_buzz", 32'(buzzer), 32'd1);
        chk("t6_pre_lap", 32'(lap_cnt), 32'd2);
        cyc(1);
        #2 reset = 1'b0;
        #1 chk_reset_vals("t6_async");
        cyc(2);
        reset = 1'b1;
        cyc(3);

        // Test 2: bouncing button yields exactly one start
        n_run_rise = 0;
        for (int i = 0; i < 3; i++) begin
            btn_ss = 1'b1;
            cyc(2);
            btn_ss = 1'b0;
            cyc(2);
        end
        chk("t2_no_start_bounce", 32'(running), 32'd0);
        btn_ss = 1'b1;
        cyc(15);
        chk("t2_running", 32'(running), 32'd1);
        btn_ss = 1'b0;
        cyc(12);
        chk("t2_one_rise", 32'(n_run_rise), 32'd1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
